lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address for RV32I loads and stores, then runs one transaction on a simple req/ack data bus.
- Aligns store data and builds byte enables; extracts and sign/zero-extends load data.
- Stalls the single-cycle core until the access completes. The core holds PC and register-file writes while `stall` is high.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, maximum cycles spent waiting for `bus_ack` (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  load/store instruction present; held by the core until `done`.
- mem_write  input  1  1 = store, 0 = load; sampled with `start`.
- funct3  input  3  RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
- addr  input  WIDTH  effective address, taken from the ALU output.
- write_data  input  WIDTH  rs2 value for stores.
- rd_data  output  WIDTH  extended load result; valid when `done`=1.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with `done`, on misalign, illegal funct3 or timeout.
- stall  output  1  combinational: `start` & ~`done`.
- bus_req  output  1  transaction request.
- bus_we  output  1  write strobe.
- bus_addr  output  WIDTH  word-aligned address: addr[31:2], 2'b00.
- bus_wdata  output  WIDTH  lane-aligned store data.
- bus_be  output  4  byte enables.
- bus_rdata  input  WIDTH  read data, valid with `bus_ack`.
- bus_ack  input  1  completion from the bus, one cycle.

Behaviour:
- Reset values (reset=0, asynchronous): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rd_data=0, done=0, err=0. Any in-flight access is abandoned and bus_req drops immediately.
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE:
  - On start=1, latch mem_write, funct3, addr[1:0] and the aligned data/enables.
  - Illegal funct3 or misaligned access -> FAULT. Illegal: loads 011/110/111, stores >010. Misaligned: H with addr[0]=1; W with addr[1:0]≠0.
  - Otherwise -> REQ, with bus_req=1 from the next cycle.
- REQ:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_be are held stable.
  - On bus_ack=1, capture the extended bus_rdata (loads) and go to DONE; bus_req is 0 from the next cycle.
  - Without the optional feature, REQ waits indefinitely.
- DONE: done=1 for exactly one cycle, err=0, -> IDLE.
- FAULT: done=1 and err=1 for one cycle; rd_data=0; no bus transaction is issued; -> IDLE.
- Latency: start to done is 2 + (ack wait) cycles. With ack in the first REQ cycle, done is high in cycle 2 after start. Fault access: done in cycle 1.
- Back-to-back accesses: start held high after done is a new instruction. It is accepted in the IDLE cycle following DONE/FAULT, so there is no lost or duplicated access.
- bus_ack outside REQ is ignored. start changes while not in IDLE are ignored; fields were latched in IDLE.
- Store alignment:
  - SB: wdata = byte replicated ×4; be = 4'b0001 << addr[1:0].
  - SH: wdata = halfword replicated ×2; be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
- Loads: bus_we=0, be=4'b1111.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rd_data holds its last value until the next completion.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A wait counter clears on REQ entry and increments each REQ cycle.
  - If it reaches TIMEOUT with no ack, bus_req drops and the FSM enters FAULT with rd_data=32'hDEADBEEF.
  - A late ack after that is ignored.
- Undefined: no counter logic; REQ waits forever for ack.

Test Plan:
- LW, addr=0x100, bus_rdata=0x89ABCDEF, ack in first REQ cycle -> bus_addr=0x100, be=4'b1111; done in cycle 2; rd_data=0x89ABCDEF; err=0; stall high in cycles 0-1.
- LB, addr=0x103, bus_rdata=0x80FF_0000 -> rd_data=0xFFFFFF80. Same data with LBU -> 0x00000080. LHU at addr=0x102 -> 0x000080FF.
- SB, addr=0x201, write_data=0x000000A5, ack delayed 3 cycles -> bus_we=1, be=4'b0010, wdata=0xA5A5A5A5 held stable throughout REQ; done 1 cycle after ack.
- SW at addr=0x102 -> no bus_req; done=err=1 in cycle 1. Next instruction, LW held start with aligned addr -> accepted in the following IDLE cycle.
- reset=0 asserted mid-REQ -> bus_req=0 immediately, no done; after release, a fresh LW completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT=4, no ack -> bus_req drops after 4 REQ cycles; done=err=1; rd_data=0xDEADBEEF; a late ack is ignored.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
// Single outstanding req/ack transaction; bus_rdata is qualified by bus_ack.
interface lsu_if #(
    parameter int WIDTH = 32
) ();
    logic             bus_req;
    logic             bus_we;
    logic [WIDTH-1:0] bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic [3:0]       bus_be;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one req/ack bus transaction per instruction, stalling the core.
// Define LSU_TIMEOUT_EN to abort a REQ that waits TIMEOUT cycles without bus_ack.
module lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             err,
    output logic             stall,
    lsu_if.master            bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t     state_q, state_d;
    logic [2:0] f3_q;
    logic [1:0] ofs_q;
    logic       bad_access;
    logic       timeout;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) return (f3 > 3'b010);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ofs);
        case (f3[1:0])
            2'b01:   return ofs[0];
            2'b10:   return (ofs != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] store_data(input logic [2:0] f3, input logic [WIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ofs);
        case (f3[1:0])
            2'b00:   return 4'b0001 << ofs;
            2'b01:   return ofs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] load_extend(input logic [2:0] f3, input logic [1:0] ofs,
                                                     input logic [WIDTH-1:0] d);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        b_s = $signed(d[{ofs, 3'b000} +: 8]);
        h_s = ofs[1] ? $signed(d[31:16]) : $signed(d[15:0]);
        case (f3)
            3'b000:  return WIDTH'(b_s);
            3'b001:  return WIDTH'(h_s);
            3'b100:  return WIDTH'($unsigned(b_s));
            3'b101:  return WIDTH'($unsigned(h_s));
            default: return d;
        endcase
    endfunction

    assign bad_access = is_illegal(mem_write, funct3) || is_misaligned(funct3, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q;

    // Counter is zero on every REQ entry because it is held clear outside REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               wait_q <= '0;
        else if (state_q != REQ)  wait_q <= '0;
        else                      wait_q <= wait_q + CNT_W'(1);
    end

    assign timeout = (state_q == REQ) && !bus.bus_ack && (wait_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = bad_access ? FAULT : REQ;
            REQ:     if (bus.bus_ack) state_d = DONE;
                     else if (timeout) state_d = FAULT;
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done  = (state_q == DONE) || (state_q == FAULT);
    assign err   = (state_q == FAULT);
    assign stall = start & ~done;

    // Bus fields are captured only for accepted accesses so they stay stable across REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= 4'b0000;
            rd_data       <= '0;
            f3_q          <= 3'b000;
            ofs_q         <= 2'b00;
        end else begin
            bus.bus_req <= (state_d == REQ);
            if (state_q == IDLE && start) begin
                f3_q  <= funct3;
                ofs_q <= addr[1:0];
                if (bad_access) begin
                    rd_data <= '0;
                end else begin
                    bus.bus_we    <= mem_write;
                    bus.bus_addr  <= {addr[WIDTH-1:2], 2'b00};
                    bus.bus_be    <= mem_write ? store_be(funct3, addr[1:0]) : 4'b1111;
                    bus.bus_wdata <= mem_write ? store_data(funct3, write_data) : '0;
                end
            end
            if (state_q == REQ) begin
                if (bus.bus_ack) begin
                    if (!bus.bus_we) rd_data <= load_extend(f3_q, ofs_q, bus.bus_rdata);
                end else if (timeout) begin
                    rd_data <= WIDTH'(32'hDEAD_BEEF);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: per-cycle comparison against a spec-level model plus literal pins.
module tb_lsu;
`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        stall;

    lsu_if #(.WIDTH(32)) bus ();

    lsu #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .write_data (write_data),
        .rd_data    (rd_data),
        .done       (done),
        .err        (err),
        .stall      (stall),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic        exp_req, exp_we, exp_done, exp_err, chk_wdata;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level model: sizes, lanes and extension computed with plain integer arithmetic.
    function automatic bit model_bad(input bit we, input int f3, input int a);
        int sz;
        if (we) begin
            if (f3 > 2) return 1'b1;
        end else if (f3 == 3 || f3 == 6 || f3 == 7) begin
            return 1'b1;
        end
        sz = 1 << (f3 % 4);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input int a, input logic [31:0] d);
        longint u;
        longint b;
        longint h;
        u = longint'(d);
        b = (u >> (8 * a)) % 256;
        h = (u >> (8 * (a - a % 2))) % 65536;
        case (f3)
            0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
            1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int f3, input int a);
        case (f3 % 4)
            0:       return 4'(1 << a);
            1:       return 4'(3 << a);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] wd);
        longint u;
        u = longint'(wd);
        case (f3 % 4)
            0:       return 32'((u % 256) * 64'h0101_0101);
            1:       return 32'((u % 65536) * 64'h0001_0001);
            default: return wd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_req", 32'(bus.bus_req), 32'(exp_req));
            check("done", 32'(done), 32'(exp_done));
            check("err", 32'(err), 32'(exp_err));
            check("stall", 32'(stall), 32'(start & ~exp_done));
            check("rd_data", rd_data, exp_rd);
            if (exp_req) begin
                check("bus_we", 32'(bus.bus_we), 32'(exp_we));
                check("bus_addr", bus.bus_addr, exp_addr);
                check("bus_be", 32'(bus.bus_be), 32'(exp_be));
                if (chk_wdata) check("bus_wdata", bus.bus_wdata, exp_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its start cycle through its done cycle; start stays high.
    task automatic access(input bit we, input int f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay);
        bit bad;
        bad = model_bad(we, f3, int'(a % 4));
        step();
        start = 1'b1; mem_write = we; funct3 = 3'(f3); addr = a; write_data = wd;
        bus.bus_ack = 1'b0;
        exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        if (bad) begin
            step();
            exp_done = 1'b1; exp_err = 1'b1; exp_rd = 32'h0;
        end else begin
            exp_we    = we;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = we ? model_be(f3, int'(a % 4)) : 4'hF;
            exp_wdata = model_wdata(f3, wd);
            chk_wdata = we;
            for (int i = 0; i <= delay; i++) begin
                step();
                exp_req = 1'b1;
                if (i == 0) begin
                    addr = a ^ 32'h0000_0FFF;
                    write_data = ~wd;
                end
                bus.bus_ack   = (i == delay);
                bus.bus_rdata = (i == delay) ? rdata : ~rdata;
            end
            step();
            bus.bus_ack = 1'b0;
            exp_req = 1'b0; exp_done = 1'b1;
            if (!we) exp_rd = model_load(f3, int'(a % 4), rdata);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step();
        start = 1'b0;
        exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; write_data = 32'h0;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
        exp_req = 1'b0; exp_we = 1'b0; exp_done = 1'b0; exp_err = 1'b0; chk_wdata = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rd = 32'h0; exp_be = 4'h0;
        step(); step();
        check("rst_bus_req", 32'(bus.bus_req), 32'h0);
        check("rst_bus_we", 32'(bus.bus_we), 32'h0);
        check("rst_bus_addr", bus.bus_addr, 32'h0);
        check("rst_bus_wdata", bus.bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus.bus_be), 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b1;
        chk_en = 1'b1;

        access(1'b0, 2, 32'h0000_0100, 32'h0, 32'h89AB_CDEF, 0);
        check("lit_lw", rd_data, 32'h89AB_CDEF);
        idle();

        // Back-to-back loads of the same word through different lanes and extensions.
        access(1'b0, 0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        check("lit_lb", rd_data, 32'hFFFF_FF80);
        access(1'b0, 4, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);
        check("lit_lbu", rd_data, 32'h0000_0080);
        access(1'b0, 5, 32'h0000_0102, 32'h0, 32'h80FF_0000, 0);
        check("lit_lhu", rd_data, 32'h0000_80FF);
        access(1'b0, 1, 32'h0000_0102, 32'h0, 32'h80FF_0000, 0);
        check("lit_lh", rd_data, 32'hFFFF_80FF);
        idle();

        access(1'b1, 0, 32'h0000_0201, 32'h0000_00A5, 32'h0, 3);
        check("lit_sb_rd_hold", rd_data, 32'hFFFF_80FF);
        idle();
        access(1'b1, 1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1);
        access(1'b1, 2, 32'h0000_0204, 32'hCAFE_0001, 32'h0, 0);
        idle();

        // Faults followed immediately by a held-start load.
        access(1'b1, 2, 32'h0000_0102, 32'h1111_1111, 32'h0, 0);
        check("lit_fault_rd", rd_data, 32'h0);
        access(1'b0, 2, 32'h0000_0104, 32'h0, 32'h1122_3344, 2);
        check("lit_after_fault", rd_data, 32'h1122_3344);
        access(1'b0, 3, 32'h0000_0100, 32'h0, 32'h0, 0);
        access(1'b1, 4, 32'h0000_0100, 32'h0, 32'h0, 0);
        access(1'b0, 1, 32'h0000_0101, 32'h0, 32'h0, 0);
        access(1'b0, 0, 32'h0000_0101, 32'h0, 32'h7F00_8000, 0);
        check("lit_lb_lane1", rd_data, 32'hFFFF_FF80);
        idle();

        // A stray ack while idle must not disturb anything.
        step();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_5555;
        step();
        bus.bus_ack = 1'b0;
        @(negedge clk);

        // Asynchronous reset while a request is outstanding.
        chk_en = 1'b0;
        step();
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        step();
        step();
        check("pre_rst_req", 32'(bus.bus_req), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.bus_req), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        step();
        check("mid_rst_done2", 32'(done), 32'h0);
        check("mid_rst_rd", rd_data, 32'h0);
        start = 1'b0;
        reset = 1'b1;
        exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rd = 32'h0;
        chk_en = 1'b1;
        idle();
        access(1'b0, 2, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0);
        check("lit_post_rst", rd_data, 32'hCAFE_F00D);
        idle();

`ifdef LSU_TIMEOUT_EN
        // No ack: request drops after TMO cycles, then a late ack is ignored.
        step();
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
        exp_we = 1'b0; exp_addr = 32'h0000_0400; exp_be = 4'hF; chk_wdata = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            step();
            exp_req = 1'b1;
        end
        step();
        exp_req = 1'b0; exp_done = 1'b1; exp_err = 1'b1; exp_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lit_timeout_rd", rd_data, 32'hDEAD_BEEF);
        step();
        start = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BAD_0BAD;
        step();
        bus.bus_ack = 1'b0;
        step();
        @(negedge clk);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
